// File: rtl/mole_round_controller.sv
// mole_round_controller
// ---------------------
// Sequences one whack-a-mole game. A start strobe clears the evaluator score
// and spawns the first mole. Each mole is placed at a pseudo-random hole taken
// from an 8-bit LFSR, and it never lands on the same hole as the previous mole.
// Each mole stays visible for a window that is counted in slow ticks. A guess
// strobe is turned into a one-cycle eval_now pulse for the score evaluator.
// A correct result blanks the board for a hold period. A wrong result returns
// to the same window with the remaining time unchanged. When the window
// expires, or the hold period ends, the next mole spawns. After the last mole
// the controller enters DONE.
//
// Optional build macro:
//   MOLE_SPEEDUP_EN - every hit shortens the window of later moles by one tick.
//                     The window never drops below MIN_TICKS. The window length
//                     goes back to MOLE_TICKS at every game start.
//
// Ports:
//   clk            system clock
//   rst            asynchronous reset, active-high
//   tick           one-cycle time-base enable for the window and hold timers
//   start          one-cycle start strobe, honoured only in IDLE or DONE
//   guess_valid    one-cycle guess strobe, honoured only while a mole is shown
//   guess_correct  registered hit flag from the evaluator, sampled in RESULT
//   mole_pos       current mole hole, 0..7
//   mole_change    one-cycle pulse in the cycle mole_pos takes a new value
//   eval_now       one-cycle evaluate strobe, one cycle after guess_valid
//   score_clr      one-cycle score clear at game start
//   mole_visible   mole is displayed
//   rounds_left    moles remaining after the current one
//   game_active    game in progress (from SPAWN of the first mole until DONE)
//   game_over      game finished
module mole_round_controller #(
   parameter int         MOLE_TICKS  = 50,
   parameter int         HOLD_TICKS  = 10,
   parameter int         GAME_ROUNDS = 30,
   parameter logic [7:0] LFSR_SEED   = 8'hA5,
   parameter int         MIN_TICKS   = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       start,
   input  logic       guess_valid,
   input  logic       guess_correct,
   output logic [2:0] mole_pos,
   output logic       mole_change,
   output logic       eval_now,
   output logic       score_clr,
   output logic       mole_visible,
   output logic [7:0] rounds_left,
   output logic       game_active,
   output logic       game_over
);

   typedef enum logic [2:0] {
      IDLE,
      SPAWN,
      SHOW,
      EVAL,
      RESULT,
      HOLD,
      DONE
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [7:0] lfsr;
   logic [7:0] lfsr_next;
   logic [7:0] timer;
   logic [7:0] timer_next;
   logic [7:0] rounds_next;
   logic [2:0] pos_next;
   logic       change_next;
   logic       clr_next;
   logic       last_round;

`ifdef MOLE_SPEEDUP_EN
   logic [7:0] window_len;
   logic [7:0] window_len_next;
`else
   localparam logic [7:0] window_len = 8'(MOLE_TICKS);
   // MIN_TICKS only matters when the speed-up build is enabled.
   logic [7:0] unused_min_ticks;
   assign unused_min_ticks = 8'(MIN_TICKS);
`endif

   // Fibonacci LFSR with taps 8,6,5,4. It runs every cycle, so the hole chosen
   // depends on how long the player took.
   assign lfsr_next  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   assign last_round = (rounds_left == 8'd0);

   always_comb begin
      state_next  = state;
      timer_next  = timer;
      rounds_next = rounds_left;
      pos_next    = mole_pos;
      change_next = 1'b0;
      clr_next    = 1'b0;
`ifdef MOLE_SPEEDUP_EN
      window_len_next = window_len;
`endif
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_next  = SPAWN;
               rounds_next = 8'(GAME_ROUNDS);
               clr_next    = 1'b1;
`ifdef MOLE_SPEEDUP_EN
               window_len_next = 8'(MOLE_TICKS);
`endif
            end
         end
         SPAWN: begin
            // When the candidate hits the current hole, move one hole along so
            // that two moles in a row never share a hole.
            pos_next    = (lfsr[2:0] == mole_pos) ? mole_pos + 3'd1 : lfsr[2:0];
            change_next = 1'b1;
            rounds_next = last_round ? 8'd0 : rounds_left - 8'd1;
            timer_next  = window_len;
            state_next  = SHOW;
         end
         SHOW: begin
            // A guess has priority. A tick in the same cycle is dropped.
            if (guess_valid) begin
               state_next = EVAL;
            end else if (tick) begin
               if (timer <= 8'd1) begin
                  timer_next = 8'd0;
                  state_next = last_round ? DONE : SPAWN;
               end else begin
                  timer_next = timer - 8'd1;
               end
            end
         end
         EVAL: begin
            state_next = RESULT;
         end
         RESULT: begin
            if (guess_correct) begin
               timer_next = 8'(HOLD_TICKS);
               state_next = HOLD;
`ifdef MOLE_SPEEDUP_EN
               if (window_len > 8'(MIN_TICKS)) begin
                  window_len_next = window_len - 8'd1;
               end
`endif
            end else begin
               // A miss leaves the remaining window untouched.
               state_next = SHOW;
            end
         end
         HOLD: begin
            if (tick) begin
               if (timer <= 8'd1) begin
                  timer_next = 8'd0;
                  state_next = last_round ? DONE : SPAWN;
               end else begin
                  timer_next = timer - 8'd1;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Every output is registered from the next-state decode. Each flag is
   // therefore already valid in the first cycle of the state it belongs to.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         lfsr         <= LFSR_SEED;
         timer        <= 8'd0;
         mole_pos     <= 3'd0;
         rounds_left  <= 8'd0;
         mole_change  <= 1'b0;
         score_clr    <= 1'b0;
         eval_now     <= 1'b0;
         mole_visible <= 1'b0;
         game_active  <= 1'b0;
         game_over    <= 1'b0;
      end else begin
         state        <= state_next;
         lfsr         <= lfsr_next;
         timer        <= timer_next;
         mole_pos     <= pos_next;
         rounds_left  <= rounds_next;
         mole_change  <= change_next;
         score_clr    <= clr_next;
         eval_now     <= (state_next == EVAL);
         mole_visible <= (state_next == SHOW) || (state_next == EVAL) ||
                         (state_next == RESULT);
         game_active  <= (state_next != IDLE) && (state_next != DONE);
         game_over    <= (state_next == DONE);
      end
   end

`ifdef MOLE_SPEEDUP_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         window_len <= 8'(MOLE_TICKS);
      end else begin
         window_len <= window_len_next;
      end
   end
`endif

endmodule
